// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS pipeline: stall/flush enables,
// operand-forwarding selects, mult/div busy sequencer and memory wait stall.
module pipeline_hazard_ctrl #(
   parameter int unsigned MULT_LAT = 4,
   parameter int unsigned DIV_LAT  = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] RsD,
   input  logic [4:0] RtD,
   input  logic [4:0] RsE,
   input  logic [4:0] RtE,
   input  logic [4:0] WriteReg_E,
   input  logic [4:0] WriteReg_M,
   input  logic [4:0] WriteReg_W,
   input  logic       RegWrite_E,
   input  logic       RegWrite_M,
   input  logic       RegWrite_W,
   input  logic       MemToReg_E,
   input  logic       MemToReg_M,
   input  logic       Branch_D,
   input  logic       PCSrc_D,
   input  logic       MfHiLo_D,
   input  logic       MulDivStart_E,
   input  logic       MulDivIsDiv_E,
   input  logic       MemReq_M,
   input  logic       MemReady_M,
   output logic       StallF,
   output logic       StallD,
   output logic       StallE,
   output logic       StallM,
   output logic       FlushD,
   output logic       FlushE,
   output logic       FlushM,
   output logic       FlushW,
   output logic [1:0] ForwardAE,
   output logic [1:0] ForwardBE,
   output logic       ForwardAD,
   output logic       ForwardBD,
   output logic       MulDivBusy,
   output logic       MulDivDone
);

   localparam int unsigned CNT_W = (DIV_LAT > 1) ? $clog2(DIV_LAT) : 1;
   localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LAT - 1);
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LAT - 1);

   typedef enum logic {ST_IDLE, ST_BUSY} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;

   logic w_memwait;
   logic w_mdstruct;
   logic w_lwstall;
   logic w_brstall;
   logic w_hilostall;
   logic w_dstall;

   // A register-file dependency that only counts when the producer writes a non-zero register.
   function automatic logic f_match(input logic [4:0] a, input logic [4:0] b, input logic we);
      return we && (b != 5'd0) && (a == b);
   endfunction

   // Hazard source decode.
   assign w_memwait   = MemReq_M && !MemReady_M;
   assign w_mdstruct  = MulDivBusy && MulDivStart_E;
   assign w_lwstall   = MemToReg_E && (f_match(RsD, WriteReg_E, 1'b1) ||
                                       f_match(RtD, WriteReg_E, 1'b1));
   assign w_brstall   = Branch_D && (f_match(RsD, WriteReg_E, RegWrite_E) ||
                                     f_match(RtD, WriteReg_E, RegWrite_E) ||
                                     f_match(RsD, WriteReg_M, MemToReg_M) ||
                                     f_match(RtD, WriteReg_M, MemToReg_M));
   assign w_hilostall = MfHiLo_D && (MulDivBusy || MulDivStart_E);
   assign w_dstall    = w_lwstall || w_brstall || w_hilostall;

   // Busy covers the done cycle; Done is suppressed while reset abandons the operation.
   assign MulDivBusy = (r_state == ST_BUSY);
   assign MulDivDone = (r_state == ST_BUSY) && (r_cnt == '0) && !reset;

   // Sequencer state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Sequencer next state: starts are refused during a memory wait; the count runs regardless.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         ST_IDLE: begin
            if (MulDivStart_E && !w_memwait) begin
               w_state_nxt = ST_BUSY;
               w_cnt_nxt   = MulDivIsDiv_E ? DIV_LOAD : MULT_LOAD;
            end
         end
         ST_BUSY: begin
            if (r_cnt == '0) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end
         end
      endcase
   end

   // Prioritised stall/flush selection and forwarding selects.
   always_comb begin
      StallF    = 1'b0;
      StallD    = 1'b0;
      StallE    = 1'b0;
      StallM    = 1'b0;
      FlushD    = 1'b0;
      FlushE    = 1'b0;
      FlushM    = 1'b0;
      FlushW    = 1'b0;
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;
      ForwardAD = 1'b0;
      ForwardBD = 1'b0;
      if (reset) begin
         FlushD = 1'b1;
         FlushE = 1'b1;
         FlushM = 1'b1;
         FlushW = 1'b1;
      end else begin
         if (f_match(RsE, WriteReg_M, RegWrite_M))      ForwardAE = 2'b10;
         else if (f_match(RsE, WriteReg_W, RegWrite_W)) ForwardAE = 2'b01;
         if (f_match(RtE, WriteReg_M, RegWrite_M))      ForwardBE = 2'b10;
         else if (f_match(RtE, WriteReg_W, RegWrite_W)) ForwardBE = 2'b01;
         ForwardAD = f_match(RsD, WriteReg_M, RegWrite_M);
         ForwardBD = f_match(RtD, WriteReg_M, RegWrite_M);

         if (w_memwait) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
         end else if (w_mdstruct) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            FlushM = 1'b1;
         end else if (w_dstall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
         end else begin
            FlushD = PCSrc_D;
         end
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed scenarios then random traffic.
module tb_pipeline_hazard_ctrl;

   localparam int unsigned MULT_LAT = 4;
   localparam int unsigned DIV_LAT  = 16;

   typedef struct packed {
      logic       rst;
      logic [4:0] rsd, rtd, rse, rte, wre, wrm, wrw;
      logic       rwe, rwm, rww, m2re, m2rm, br, pcsrc, mfhl, mds, isdiv, mreq, mrdy;
   } stim_t;

   typedef struct packed {
      logic [3:0] stall;   // {F,D,E,M}
      logic [3:0] flush;   // {D,E,M,W}
      logic [1:0] fae, fbe;
      logic       fad, fbd;
      logic       busy, done, md_known;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] RsD, RtD, RsE, RtE, WriteReg_E, WriteReg_M, WriteReg_W;
   logic       RegWrite_E, RegWrite_M, RegWrite_W, MemToReg_E, MemToReg_M;
   logic       Branch_D, PCSrc_D, MfHiLo_D, MulDivStart_E, MulDivIsDiv_E, MemReq_M, MemReady_M;
   logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW;
   logic [1:0] ForwardAE, ForwardBE;
   logic       ForwardAD, ForwardBD, MulDivBusy, MulDivDone;

   pipeline_hazard_ctrl #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
      .clk(clk), .reset(reset),
      .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
      .WriteReg_E(WriteReg_E), .WriteReg_M(WriteReg_M), .WriteReg_W(WriteReg_W),
      .RegWrite_E(RegWrite_E), .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W),
      .MemToReg_E(MemToReg_E), .MemToReg_M(MemToReg_M),
      .Branch_D(Branch_D), .PCSrc_D(PCSrc_D), .MfHiLo_D(MfHiLo_D),
      .MulDivStart_E(MulDivStart_E), .MulDivIsDiv_E(MulDivIsDiv_E),
      .MemReq_M(MemReq_M), .MemReady_M(MemReady_M),
      .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
      .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
      .MulDivBusy(MulDivBusy), .MulDivDone(MulDivDone)
   );

   always #5 clk = ~clk;

   exp_t q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   cyc      = 0;

   // Reference mult/div model: number of busy cycles still to run, including the current one.
   int   md_left  = 0;
   bit   md_known = 0;

   function automatic bit dep(input logic [4:0] a, input logic [4:0] b, input logic we);
      return (we == 1'b1) && (b != 5'd0) && (a == b);
   endfunction

   function automatic exp_t model_out(input stim_t s);
      exp_t e;
      bit   busy, memwait, mdstruct, dstall;
      e = '0;
      busy       = (md_left > 0);
      e.md_known = md_known;
      e.busy     = busy;
      e.done     = (md_left == 1) && !s.rst;
      if (s.rst) begin
         e.flush = 4'b1111;
         return e;
      end
      e.fae = dep(s.rse, s.wrm, s.rwm) ? 2'd2 : (dep(s.rse, s.wrw, s.rww) ? 2'd1 : 2'd0);
      e.fbe = dep(s.rte, s.wrm, s.rwm) ? 2'd2 : (dep(s.rte, s.wrw, s.rww) ? 2'd1 : 2'd0);
      e.fad = dep(s.rsd, s.wrm, s.rwm);
      e.fbd = dep(s.rtd, s.wrm, s.rwm);
      memwait  = s.mreq && !s.mrdy;
      mdstruct = busy && s.mds;
      dstall   = (s.m2re && (dep(s.rsd, s.wre, 1'b1) || dep(s.rtd, s.wre, 1'b1)))
              || (s.br && (dep(s.rsd, s.wre, s.rwe) || dep(s.rtd, s.wre, s.rwe) ||
                           dep(s.rsd, s.wrm, s.m2rm) || dep(s.rtd, s.wrm, s.m2rm)))
              || (s.mfhl && (busy || s.mds));
      if (memwait)       begin e.stall = 4'b1111; e.flush = 4'b0001; end
      else if (mdstruct) begin e.stall = 4'b1110; e.flush = 4'b0010; end
      else if (dstall)   begin e.stall = 4'b1100; e.flush = 4'b0100; end
      else               e.flush = {s.pcsrc, 3'b000};
      return e;
   endfunction

   task automatic model_advance(input stim_t s);
      if (s.rst) begin
         md_left  = 0;
         md_known = 1;
      end else if (md_left > 0) begin
         md_left = md_left - 1;
      end else if (s.mds && !(s.mreq && !s.mrdy)) begin
         md_left = s.isdiv ? int'(DIV_LAT) : int'(MULT_LAT);
      end
   endtask

   function automatic stim_t idle_stim();
      stim_t s;
      s      = '0;
      s.mrdy = 1'b1;
      return s;
   endfunction

   // Apply one cycle of stimulus and queue the response the model predicts for it.
   task automatic step(input stim_t s);
      @(posedge clk);
      #1;
      reset = s.rst; RsD = s.rsd; RtD = s.rtd; RsE = s.rse; RtE = s.rte;
      WriteReg_E = s.wre; WriteReg_M = s.wrm; WriteReg_W = s.wrw;
      RegWrite_E = s.rwe; RegWrite_M = s.rwm; RegWrite_W = s.rww;
      MemToReg_E = s.m2re; MemToReg_M = s.m2rm; Branch_D = s.br; PCSrc_D = s.pcsrc;
      MfHiLo_D = s.mfhl; MulDivStart_E = s.mds; MulDivIsDiv_E = s.isdiv;
      MemReq_M = s.mreq; MemReady_M = s.mrdy;
      q.push_back(model_out(s));
      model_advance(s);
   endtask

   task automatic chk(input string name, input int got, input int want);
      n_checks++;
      if (got == want) n_pass++;
      else $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, got, want);
   endtask

   // Monitor: the DUT presents a response every cycle; compare it mid-cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() != 0) begin
            e = q.pop_front();
            cyc++;
            chk("stall", int'({StallF, StallD, StallE, StallM}), int'(e.stall));
            chk("flush", int'({FlushD, FlushE, FlushM, FlushW}), int'(e.flush));
            chk("fwdE",  int'({ForwardAE, ForwardBE}), int'({e.fae, e.fbe}));
            chk("fwdD",  int'({ForwardAD, ForwardBD}), int'({e.fad, e.fbd}));
            if (e.md_known) chk("muldiv", int'({MulDivBusy, MulDivDone}), int'({e.busy, e.done}));
         end
      end
   end

   initial begin
      stim_t s;
      reset = 1'b1;
      {RsD, RtD, RsE, RtE, WriteReg_E, WriteReg_M, WriteReg_W} = '0;
      {RegWrite_E, RegWrite_M, RegWrite_W, MemToReg_E, MemToReg_M} = '0;
      {Branch_D, PCSrc_D, MfHiLo_D, MulDivStart_E, MulDivIsDiv_E, MemReq_M} = '0;
      MemReady_M = 1'b1;

      // Reset.
      s = idle_stim(); s.rst = 1'b1;
      step(s); step(s);

      // Forwarding: M beats W, then W alone, then $0 never forwards.
      s = idle_stim(); s.rse = 5'd3; s.wrm = 5'd3; s.rwm = 1'b1; s.wrw = 5'd3; s.rww = 1'b1;
      step(s);
      s.rwm = 1'b0; step(s);
      s.rse = 5'd0; s.wrm = 5'd0; s.wrw = 5'd0; s.rwm = 1'b1; step(s);

      // Load-use: stall one cycle, then forward from the load now in M.
      s = idle_stim(); s.m2re = 1'b1; s.rwe = 1'b1; s.wre = 5'd5; s.rtd = 5'd5;
      step(s);
      s = idle_stim(); s.rse = 5'd5; s.rte = 5'd7; s.wrm = 5'd5; s.rwm = 1'b1; s.m2rm = 1'b1;
      step(s);

      // Taken branch: redirect flush alone, then suppressed by a load-use stall.
      s = idle_stim(); s.br = 1'b1; s.pcsrc = 1'b1; s.rsd = 5'd1; s.rtd = 5'd2;
      step(s);
      s.m2re = 1'b1; s.rwe = 1'b1; s.wre = 5'd2; step(s);

      // DIV with MFHI waiting, and a MULT arriving in the done cycle.
      s = idle_stim(); s.mds = 1'b1; s.isdiv = 1'b1;
      step(s);
      for (int i = 1; i <= int'(DIV_LAT) + 1; i++) begin
         s = idle_stim(); s.mfhl = (i <= int'(DIV_LAT));
         s.mds = (i >= int'(DIV_LAT));
         step(s);
      end
      for (int i = 0; i < int'(MULT_LAT) + 2; i++) step(idle_stim());

      // Memory wait on top of a load-use stall, then release.
      s = idle_stim(); s.m2re = 1'b1; s.wre = 5'd4; s.rsd = 5'd4; s.mreq = 1'b1; s.mrdy = 1'b0;
      step(s); step(s); step(s);
      s.mrdy = 1'b1; step(s);

      // Reset in the middle of a DIV, then a fresh MULT.
      s = idle_stim(); s.mds = 1'b1; s.isdiv = 1'b1; step(s);
      for (int i = 0; i < 4; i++) step(idle_stim());
      s = idle_stim(); s.rst = 1'b1; s.wrm = 5'd2; s.rse = 5'd2; s.rwm = 1'b1; step(s);
      step(idle_stim());
      s = idle_stim(); s.mds = 1'b1; step(s);
      for (int i = 0; i < int'(MULT_LAT) + 2; i++) step(idle_stim());

      // Random traffic with a small register pool to provoke dependencies.
      for (int i = 0; i < 1500; i++) begin
         s       = idle_stim();
         s.rst   = ($urandom_range(0, 63) == 0);
         s.rsd   = 5'($urandom_range(0, 3)); s.rtd = 5'($urandom_range(0, 3));
         s.rse   = 5'($urandom_range(0, 3)); s.rte = 5'($urandom_range(0, 3));
         s.wre   = 5'($urandom_range(0, 3)); s.wrm = 5'($urandom_range(0, 3));
         s.wrw   = 5'($urandom_range(0, 3));
         s.rwe   = 1'($urandom_range(0, 1)); s.rwm = 1'($urandom_range(0, 1));
         s.rww   = 1'($urandom_range(0, 1));
         s.m2re  = ($urandom_range(0, 3) == 0); s.m2rm = ($urandom_range(0, 3) == 0);
         s.br    = ($urandom_range(0, 3) == 0); s.pcsrc = ($urandom_range(0, 3) == 0);
         s.mfhl  = ($urandom_range(0, 4) == 0);
         s.mds   = ($urandom_range(0, 5) == 0); s.isdiv = 1'($urandom_range(0, 1));
         s.mreq  = ($urandom_range(0, 2) == 0); s.mrdy = 1'($urandom_range(0, 1));
         step(s);
      end

      for (int i = 0; i < 5 && q.size() != 0; i++) @(negedge clk);
      @(negedge clk);
      n_checks++;
      if (q.size() == 0) n_pass++;
      else $display("FAIL drain: %0d responses never compared, expected 0", q.size());
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central sequencing controller for the 5-stage MIPS pipeline. It generates the stall and flush enables for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, and the operand-forwarding selects for the D and E stages. It also owns the multi-cycle MULT/DIV unit busy sequencer and the data-memory wait-state stall. It sits beside the datapath and drives only control; it holds no data.

Parameters:
MULT_LAT, 4, cycles a MULT/MULTU occupies the mult/div unit (>=1)
DIV_LAT, 16, cycles a DIV/DIVU occupies the mult/div unit (>=1, >=MULT_LAT)

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
RsD, RtD  in  5  source registers of the instruction in D
RsE, RtE  in  5  source registers of the instruction in E
WriteReg_E, WriteReg_M, WriteReg_W  in  5  destination register per stage
RegWrite_E, RegWrite_M, RegWrite_W  in  1  register write enable per stage
MemToReg_E, MemToReg_M  in  1  instruction in that stage is a load
Branch_D  in  1  branch instruction in D
PCSrc_D  in  1  branch taken or jump redirect resolved in D
MfHiLo_D  in  1  instruction in D reads HI/LO
MulDivStart_E  in  1  MULT/DIV instruction in E
MulDivIsDiv_E  in  1  1 = divide, 0 = multiply
MemReq_M  in  1  load/store in M
MemReady_M  in  1  data memory completes the access this cycle
StallF, StallD, StallE, StallM  out  1  hold the PC / IF-ID / ID-EX / EX-MEM register
FlushD, FlushE, FlushM, FlushW  out  1  load a bubble into IF-ID / ID-EX / EX-MEM / MEM-WB
ForwardAE, ForwardBE  out  2  E operand select: 00 regfile, 01 from W, 10 from M
ForwardAD, ForwardBD  out  1  D comparator operand from M
MulDivBusy  out  1  mult/div unit occupied
MulDivDone  out  1  one-cycle pulse: HI/LO written this cycle

Behaviour:
- Define match(a,b,we) = we && b!=0 && a==b. All stall, flush and forward outputs are combinational from inputs and state.
- Forwarding:
  - ForwardAE = 10 if match(RsE,WriteReg_M,RegWrite_M); else 01 if match(RsE,WriteReg_W,RegWrite_W); else 00. ForwardBE is the same using RtE. The M stage has priority over W.
  - ForwardAD = match(RsD,WriteReg_M,RegWrite_M). ForwardBD is the same using RtD.
- Stall sources, highest priority first:
  1. memwait = MemReq_M && !MemReady_M. Asserts StallF, StallD, StallE, StallM and FlushW. All other flushes are 0.
  2. mdstruct = MulDivBusy && MulDivStart_E. Asserts StallF, StallD, StallE and FlushM.
  3. dstall = lwstall | brstall | hilostall. Asserts StallF, StallD and FlushE.
     - lwstall = MemToReg_E && (match(RsD,WriteReg_E,1) || match(RtD,WriteReg_E,1)).
     - brstall = Branch_D && (match(RsD/RtD,WriteReg_E,RegWrite_E) || match(RsD/RtD,WriteReg_M,MemToReg_M)).
     - hilostall = MfHiLo_D && (MulDivBusy || MulDivStart_E).
  4. FlushD = PCSrc_D, only when none of the stall sources above is active.
  - Any output not asserted by the active source is 0.
- Mult/div sequencer:
  - States IDLE and BUSY. Down-counter cnt is wide enough for DIV_LAT-1.
  - IDLE: if MulDivStart_E && !memwait, load cnt = (MulDivIsDiv_E ? DIV_LAT : MULT_LAT) - 1 and go to BUSY. A start during memwait is not accepted; it is retried while E is held.
  - BUSY: if cnt==0, assert MulDivDone for this cycle and go to IDLE next cycle; otherwise cnt decrements.
  - cnt keeps decrementing during memwait (the unit runs independently of the pipeline).
  - MulDivBusy = (state==BUSY), including the done cycle. A back-to-back start therefore sees mdstruct in the done cycle and is accepted the following cycle.
  - LAT=1: BUSY lasts exactly one cycle, with Done asserted in that cycle.
- Reset:
  - Synchronous. Next state IDLE, cnt=0, MulDivDone=0.
  - While reset is high: all stalls 0, FlushD/E/M/W = 1, forwards 0, regardless of other inputs.
  - Reset while BUSY abandons the operation with no Done pulse.

Test Plan:
- ADD $3 in M, SUB using $3 as Rs in E, with $3 also in W -> ForwardAE=10. Remove M's RegWrite -> ForwardAE=01. Use WriteReg=$0 -> ForwardAE=00.
- LW $5 in E, Rt_D=5 -> StallF=StallD=FlushE=1 for 1 cycle. The next cycle, with the load in M and RsE=5, gives ForwardBE=00 and ForwardAE=10.
- Taken BEQ (PCSrc_D=1, no hazard) -> FlushD=1 and all stalls 0. The same with lwstall active -> FlushD=0 and StallD=1.
- DIV started at cycle 0 -> MulDivBusy high for cycles 1..16 and MulDivDone high in cycle 16 only. MFHI in D during cycles 1..16 stalls, then proceeds at cycle 17. A MULT in E at cycle 16 is accepted at cycle 17 and done at cycle 21.
- MemReq_M=1, MemReady_M=0 for 3 cycles during a lwstall -> StallF/D/E/M=1 and FlushW=1, FlushE=0, for those 3 cycles. Lwstall behaviour resumes once MemReady_M=1.
- Reset asserted at cycle 5 of a DIV -> Busy=0 next cycle, no Done pulse, FlushD..W=1 during reset. A new MULT after reset completes in MULT_LAT cycles.
